// File: rtl/roman_sym_serializer.sv
// Serializes a packed Roman-symbol vector one symbol per beat, leftmost written first.
// NULL slots are skipped; an all-NULL vector yields a single NULL beat marked last.
module roman_sym_serializer #(
    parameter int unsigned          OUT_WIDTH = 3,
    parameter int unsigned          OUT_NUM   = 6,
    parameter logic [OUT_WIDTH-1:0] SYM_NULL  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [OUT_WIDTH*OUT_NUM-1:0] in_syms_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OUT_WIDTH-1:0]         out_sym_o,
    output logic                         out_last_o,
    output logic                         busy_o
);

    localparam int unsigned VecW = OUT_WIDTH * OUT_NUM;
    localparam int unsigned PtrW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e                 state_q;
    logic [VecW-1:0]        syms_q;
    logic [PtrW-1:0]        ptr_q;
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   out_sym_q;
    logic                   out_last_q;

    // Returns {found, index} of the highest non-null slot strictly below limit.
    function automatic logic [PtrW:0] find_below(input logic [VecW-1:0] v,
                                                 input int unsigned limit);
        logic [PtrW:0] r;
        r = '0;
        for (int unsigned k = 0; k < OUT_NUM; k++) begin
            if (k < limit && v[k*OUT_WIDTH +: OUT_WIDTH] != SYM_NULL) begin
                r = {1'b1, PtrW'(k)};
            end
        end
        return r;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] slot_of(input logic [VecW-1:0] v,
                                                     input logic [PtrW-1:0] idx);
        return v[32'(idx)*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    logic [PtrW:0]        first_hit, first_rest, next_hit, next_rest;
    logic [OUT_WIDTH-1:0] first_sym, next_sym;

    always_comb begin
        first_hit  = find_below(in_syms_i, OUT_NUM);
        first_rest = find_below(in_syms_i, 32'(first_hit[PtrW-1:0]));
        first_sym  = slot_of(in_syms_i, first_hit[PtrW-1:0]);
        next_hit   = find_below(syms_q, 32'(ptr_q));
        next_rest  = find_below(syms_q, 32'(next_hit[PtrW-1:0]));
        next_sym   = slot_of(syms_q, next_hit[PtrW-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            syms_q      <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        state_q     <= StSend;
                        syms_q      <= in_syms_i;
                        out_valid_q <= 1'b1;
                        if (first_hit[PtrW]) begin
                            ptr_q      <= first_hit[PtrW-1:0];
                            out_sym_q  <= first_sym;
                            out_last_q <= ~first_rest[PtrW];
                        end else begin
                            // Zero input: a lone NULL beat marks end-of-number.
                            ptr_q      <= '0;
                            out_sym_q  <= SYM_NULL;
                            out_last_q <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (out_ready_i) begin
                        if (out_last_q) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            out_sym_q   <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            ptr_q      <= next_hit[PtrW-1:0];
                            out_sym_q  <= next_sym;
                            out_last_q <= ~next_rest[PtrW];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign out_sym_o   = out_sym_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q == StSend);

endmodule

// File: tb/tb_roman_sym_serializer.sv
// Directed and randomized checks of roman_sym_serializer against a queue-based model
// that lists the non-null symbols from the highest slot downwards.
module tb_roman_sym_serializer;

    localparam int W = 3;
    localparam int N = 6;
    localparam int VW = W * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_syms;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sym;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    roman_sym_serializer #(.OUT_WIDTH(W), .OUT_NUM(N), .SYM_NULL(3'b000)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_syms_i  (in_syms),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sym_o  (out_sym),
        .out_last_o (out_last),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the written numeral reads slots from highest to lowest, nulls dropped.
    task automatic build_expected(input logic [VW-1:0] vec);
        logic [VW-1:0] s;
        exp_q.delete();
        for (int k = N - 1; k >= 0; k--) begin
            s = (vec >> (W * k)) & 18'h7;
            if (s != 0) exp_q.push_back(int'(s));
        end
        if (exp_q.size() == 0) exp_q.push_back(0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_numeral(input logic [VW-1:0] vec, input int stall_beat,
                               input int stall_cycles, input bit rnd, input int abort_after);
        int b = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit rdy;
        int cycles = 0;
        build_expected(vec);
        check_idle("pre");
        in_valid = 1'b1;
        in_syms  = vec;
        @(posedge clk);
        @(negedge clk);
        while (b < exp_q.size()) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("in_ready", 32'(in_ready), 32'd0);
            check("busy", 32'(busy), 32'd1);
            check($sformatf("sym beat%0d", b), 32'(out_sym), 32'(exp_q[b]));
            check($sformatf("last beat%0d", b), 32'(out_last),
                  32'(b == exp_q.size() - 1));
            if (b == stall_beat && !stalled) begin
                stalled    = 1;
                stall_left = stall_cycles;
            end
            if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end else if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            in_syms   = VW'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (rdy) b++;
            cycles++;
            if (b == abort_after) begin
                in_valid = 1'b0;
                return;
            end
            if (cycles > 200) begin
                check("timeout", 32'(b), 32'(exp_q.size()));
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_idle("post");
    endtask

    logic [VW-1:0] v;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_syms   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_sym", 32'(out_sym), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_idle("release");
        @(negedge clk);

        // 4 = IV
        run_numeral({12'b0, 3'b001, 3'b010}, -1, 0, 0, -1);
        @(negedge clk);
        // 28 = XXVIII
        run_numeral({3'b011, 3'b011, 3'b010, 3'b001, 3'b001, 3'b001}, -1, 0, 0, -1);
        // 0 -> single NULL beat
        run_numeral('0, -1, 0, 0, -1);
        // 9 = IX with downstream stalled three cycles at the first beat
        run_numeral({12'b0, 3'b001, 3'b011}, 0, 3, 0, -1);

        // Reset part-way through 28
        run_numeral({3'b011, 3'b011, 3'b010, 3'b001, 3'b001, 3'b001}, -1, 0, 0, 2);
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("midrst release");
        run_numeral({15'b0, 3'b010}, -1, 0, 0, -1);

        // Interior null: X, NULL, I
        run_numeral({9'b0, 3'b011, 3'b000, 3'b001}, -1, 0, 0, -1);
        // Codes above L pass through untouched
        run_numeral({9'b0, 3'b111, 3'b101, 3'b110}, 1, 2, 0, -1);

        for (int n = 0; n < 30; n++) begin
            v = '0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) v = v | (VW'($urandom_range(1, 7)) << (W * k));
            end
            run_numeral(v, -1, 0, 1, -1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
